// File: rtl/onewire_seq.sv
// 1-Wire byte sequencer driving a 1-bit PIO as an open-drain line; bus writes are combinational on state, and the low write follows the accept cycle.
// One command in flight: cmd_ready is high in IDLE only, and rsp_valid pulses for one cycle at completion.
module onewire_seq #(
  parameter int CLK_HZ = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_presence,
  output logic        busy,
  output logic [2:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  input  logic [31:0] m_readdata
);

  localparam int DIV = CLK_HZ / 1_000_000;
  localparam int TW  = $clog2(480 * DIV + 1);

  localparam logic [1:0] OP_RST = 2'd0;
  localparam logic [1:0] OP_WR  = 2'd1;
  localparam logic [1:0] OP_RD  = 2'd2;

  typedef enum logic [3:0] {
    INIT0, INIT1, IDLE,
    RST_LOW, RST_REL, RST_SAMPLE, RST_REC,
    SLOT_LOW, SLOT_REL, SLOT_SAMPLE, SLOT_REC,
    DONE
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tmr, dur_m1;
  logic [2:0]    bit_cnt;
  logic [1:0]    op;
  logic [7:0]    wr_byte, rx_byte;
  logic          tmr_end, is_read, wr_bit, accept, capture;
  logic          unused_rd;

  assign is_read   = (op == OP_RD);
  assign wr_bit    = wr_byte[bit_cnt];
  assign accept    = cmd_valid && cmd_ready;
  assign tmr_end   = (tmr == dur_m1);
  assign unused_rd = ^m_readdata[31:1];

  // The sample cycle sits between release and recovery, so recovery is one cycle short.
  always_comb begin
    dur_m1 = '0;
    case (state)
      RST_LOW:  dur_m1 = TW'(480 * DIV - 1);
      RST_REL:  dur_m1 = TW'(70 * DIV - 1);
      RST_REC:  dur_m1 = TW'(410 * DIV - 2);
      SLOT_LOW: dur_m1 = (is_read || wr_bit) ? TW'(6 * DIV - 1) : TW'(60 * DIV - 1);
      SLOT_REL: dur_m1 = is_read ? TW'(9 * DIV - 1) : '0;
      SLOT_REC: dur_m1 = is_read ? TW'(55 * DIV - 2)
                       : (wr_bit ? TW'(64 * DIV - 2) : TW'(10 * DIV - 2));
      default:  dur_m1 = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INIT0;
      tmr   <= '0;
    end else begin
      state <= state_nxt;
      tmr   <= (state_nxt != state) ? '0 : tmr + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      INIT0:       state_nxt = INIT1;
      INIT1:       state_nxt = IDLE;
      IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_RST:       state_nxt = RST_LOW;
            OP_WR, OP_RD: state_nxt = SLOT_LOW;
            default:      state_nxt = DONE;
          endcase
        end
      end
      RST_LOW:     if (tmr_end) state_nxt = RST_REL;
      RST_REL:     if (tmr_end) state_nxt = RST_SAMPLE;
      RST_SAMPLE:  state_nxt = RST_REC;
      RST_REC:     if (tmr_end) state_nxt = DONE;
      SLOT_LOW:    if (tmr_end) state_nxt = SLOT_REL;
      SLOT_REL:    if (tmr_end) state_nxt = is_read ? SLOT_SAMPLE : SLOT_REC;
      SLOT_SAMPLE: state_nxt = SLOT_REC;
      SLOT_REC:    if (tmr_end) state_nxt = (bit_cnt == 3'd7) ? DONE : SLOT_LOW;
      DONE:        state_nxt = IDLE;
      default:     state_nxt = INIT0;
    endcase
  end

  // The PIO registers its read data, so the sampled pin shows up on the first recovery cycle.
  assign capture = (tmr == '0) && ((state == RST_REC) || (state == SLOT_REC && is_read));

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt      <= '0;
      op           <= '0;
      wr_byte      <= '0;
      rx_byte      <= '0;
      rsp_data     <= '0;
      rsp_presence <= 1'b0;
    end else begin
      if (accept) begin
        op      <= cmd_op;
        wr_byte <= cmd_data;
        bit_cnt <= '0;
      end
      if (capture) begin
        if (state == RST_REC) rsp_presence <= ~m_readdata[0];
        else                  rx_byte[bit_cnt] <= m_readdata[0];
      end
      if (state == SLOT_REC && tmr_end) begin
        bit_cnt <= bit_cnt + 1'b1;
        if (is_read && bit_cnt == 3'd7) rsp_data <= rx_byte;
      end
    end
  end

  // Bus strobes are masked while reset is held so an aborted slot stops at once.
  always_comb begin
    cmd_ready    = (state == IDLE);
    busy         = ~cmd_ready;
    rsp_valid    = (state == DONE) && !reset;
    m_address    = '0;
    m_chipselect = 1'b0;
    m_write_n    = 1'b1;
    m_writedata  = '0;
    if (!reset) begin
      case (state)
        INIT0: begin
          m_chipselect = 1'b1;
          m_write_n    = 1'b0;
        end
        INIT1, RST_REL, SLOT_REL: begin
          if (tmr == '0) begin
            m_address    = 3'd1;
            m_chipselect = 1'b1;
            m_write_n    = 1'b0;
          end
        end
        RST_LOW, SLOT_LOW: begin
          if (tmr == '0) begin
            m_address    = 3'd1;
            m_chipselect = 1'b1;
            m_write_n    = 1'b0;
            m_writedata  = 32'd1;
          end
        end
        RST_SAMPLE, SLOT_SAMPLE: m_chipselect = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_onewire_seq.sv
// Scoreboard bench for onewire_seq at 4 MHz: expected PIO accesses and responses are queued
// with their exact cycle numbers at accept time and matched as the DUT produces them.
module tb_onewire_seq;

  localparam int STEP = 280;

  localparam logic [5:0] EV_LOW  = 6'h05;
  localparam logic [5:0] EV_REL  = 6'h04;
  localparam logic [5:0] EV_CLR  = 6'h00;
  localparam logic [5:0] EV_SAMP = 6'h02;

  logic        clk, reset, cmd_valid, cmd_ready, rsp_valid, rsp_presence, busy;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_data, rsp_data;
  logic [2:0]  m_address;
  logic        m_chipselect, m_write_n;
  logic [31:0] m_writedata;
  logic [31:0] rdata = '0;

  onewire_seq #(.CLK_HZ(4_000_000)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_presence(rsp_presence), .busy(busy),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .m_readdata(rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_acc = 0;
  logic [63:0] bus_q[$];
  logic [63:0] rsp_q[$];
  logic [7:0]  last_rd   = '0;
  logic        last_pres = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] bev(input logic [5:0] code, input int c);
    return {26'd0, code, c};
  endfunction

  function automatic logic [63:0] rv(input int c, input logic [7:0] d, input logic p);
    return {23'd0, c, d, p};
  endfunction

  // PIO model: direction bit at address 1, output bit at address 0, line pulled high.
  logic dir = 1'b0, outreg = 1'b0, slave_low, line;
  int   smode = 0, ps = 0, pe = 0, sbase = 0, rel_t;
  logic [7:0] sbyte = '0;

  always_comb begin
    slave_low = 1'b0;
    rel_t     = cyc - sbase;
    if (smode == 1 && cyc >= ps && cyc < pe) slave_low = 1'b1;
    if (smode == 2 && rel_t >= 0 && rel_t < 8 * STEP)
      if (!sbyte[rel_t / STEP] && (rel_t % STEP) < 120) slave_low = 1'b1;
  end

  assign line = !((dir && !outreg) || slave_low);

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (m_chipselect && !m_write_n) begin
      if (m_address == 3'd1) dir <= m_writedata[0];
      else if (m_address == 3'd0) outreg <= m_writedata[0];
    end
    rdata <= {31'd0, (m_address == 3'd0) ? line : dir};
  end

  logic [5:0] code;
  always @(negedge clk) begin
    if (m_chipselect) begin
      code = {|m_writedata[31:1], m_address, m_write_n, m_writedata[0]};
      if (bus_q.size() == 0) check("bus_unexpected", bev(code, cyc), 64'hFFFF_FFFF_FFFF_FFFF);
      else                   check("bus_event", bev(code, cyc), bus_q.pop_front());
    end
    if (rsp_valid) begin
      if (rsp_q.size() == 0) check("rsp_unexpected", rv(cyc, rsp_data, rsp_presence), 64'hFFFF_FFFF_FFFF_FFFF);
      else                   check("rsp", rv(cyc, rsp_data, rsp_presence), rsp_q.pop_front());
    end
    if (cmd_valid && cmd_ready && !reset) n_acc++;
  end

  task automatic push_wbits(input logic [7:0] d, input int a, input int n);
    for (int i = 0; i < n; i++) begin
      bus_q.push_back(bev(EV_LOW, a + 1 + i * STEP));
      bus_q.push_back(bev(EV_REL, a + 1 + i * STEP + (d[i] ? 24 : 240)));
    end
  endtask

  task automatic push_cmd(input logic [1:0] op, input logic [7:0] d, input int a, input logic pres);
    case (op)
      2'd0: begin
        bus_q.push_back(bev(EV_LOW, a + 1));
        bus_q.push_back(bev(EV_REL, a + 1 + 1920));
        bus_q.push_back(bev(EV_SAMP, a + 1 + 2200));
        last_pres = pres;
        rsp_q.push_back(rv(a + 3841, last_rd, last_pres));
      end
      2'd1: begin
        push_wbits(d, a, 8);
        rsp_q.push_back(rv(a + 1 + 8 * STEP, last_rd, last_pres));
      end
      2'd2: begin
        for (int i = 0; i < 8; i++) begin
          bus_q.push_back(bev(EV_LOW, a + 1 + i * STEP));
          bus_q.push_back(bev(EV_REL, a + 1 + i * STEP + 24));
          bus_q.push_back(bev(EV_SAMP, a + 1 + i * STEP + 60));
        end
        last_rd = d;
        rsp_q.push_back(rv(a + 1 + 8 * STEP, last_rd, last_pres));
      end
      default: rsp_q.push_back(rv(a + 1, last_rd, last_pres));
    endcase
  endtask

  task automatic issue(input logic [1:0] op, input logic [7:0] d, output int a);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d; a = -1;
    for (int n = 0; n < 50 && a < 0; n++) begin
      @(negedge clk);
      if (cmd_ready) a = cyc;
    end
    if (a < 0) check("accept_timeout", {63'd0, cmd_ready}, 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((bus_q.size() != 0 || rsp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (bus_q.size() != 0 || rsp_q.size() != 0) begin
      check("done_timeout", 64'(bus_q.size() + rsp_q.size()), 64'd0);
      bus_q.delete();
      rsp_q.delete();
    end
  endtask

  task automatic do_reset(input int n);
    int base;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd1);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_rsp_data", {56'd0, rsp_data}, 64'd0);
    check("rst_presence", {63'd0, rsp_presence}, 64'd0);
    check("rst_bus", {27'd0, m_address, m_chipselect, m_write_n, m_writedata}, {27'd0, 3'd0, 1'b0, 1'b1, 32'd0});
    last_rd = '0;
    last_pres = 1'b0;
    repeat (n - 1) @(posedge clk);
    #1;
    reset = 1'b0;
    base = cyc;
    bus_q.push_back(bev(EV_CLR, base));
    bus_q.push_back(bev(EV_REL, base + 1));
    @(negedge clk);
    @(negedge clk);
    check("init1_cmd_ready", {63'd0, cmd_ready}, 64'd0);
    @(negedge clk);
    check("idle_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check("line_released", {63'd0, dir}, 64'd0);
  endtask

  initial begin
    int a, a2, acc0;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0;
    do_reset(3);

    smode = 1;
    issue(2'd0, 8'h00, a);
    ps = a + 2001; pe = ps + 720;
    push_cmd(2'd0, 8'h00, a, 1'b1);
    wait_idle(5000);

    smode = 0;
    issue(2'd0, 8'h00, a);
    push_cmd(2'd0, 8'h00, a, 1'b0);
    wait_idle(5000);

    issue(2'd1, 8'hA5, a);
    push_cmd(2'd1, 8'hA5, a, 1'b0);
    wait_idle(3000);

    issue(2'd2, 8'h00, a);
    sbase = a + 1; sbyte = 8'h3C; smode = 2;
    push_cmd(2'd2, 8'h3C, a, 1'b0);
    wait_idle(3000);
    smode = 0;

    issue(2'd3, 8'h00, a);
    push_cmd(2'd3, 8'h00, a, 1'b0);
    wait_idle(20);

    // Abort a write while bit 3 (a zero, long low) is being driven.
    issue(2'd1, 8'hA5, a);
    push_wbits(8'hA5, a, 3);
    bus_q.push_back(bev(EV_LOW, a + 1 + 3 * STEP));
    while (cyc < a + 1 + 3 * STEP + 10) @(posedge clk);
    do_reset(2);

    issue(2'd2, 8'h00, a);
    sbase = a + 1; sbyte = 8'hC3; smode = 2;
    push_cmd(2'd2, 8'hC3, a, 1'b0);
    wait_idle(3000);
    smode = 0;

    // cmd_valid held high across a whole command: the next accept lands right after DONE.
    acc0 = n_acc;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_op = 2'd1; cmd_data = 8'h0F; a = -1; a2 = -1;
    for (int n = 0; n < 50 && a < 0; n++) begin
      @(negedge clk);
      if (cmd_ready) a = cyc;
    end
    push_cmd(2'd1, 8'h0F, a, 1'b0);
    @(posedge clk); #1;
    cmd_op = 2'd3;
    for (int n = 0; n < 3000 && a2 < 0; n++) begin
      @(negedge clk);
      if (cmd_ready) a2 = cyc;
    end
    check("b2b_accept_cycle", 64'(a2), 64'(a + 2 + 8 * STEP));
    push_cmd(2'd3, 8'h00, a2, 1'b0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    wait_idle(50);
    repeat (3) @(negedge clk);
    check("b2b_accept_count", 64'(n_acc - acc0), 64'd2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
